// File: rtl/smartlift_pkg.sv
// smartlift_pkg: shared types, sizes and bitmap helpers for the smartlift controller.
package smartlift_pkg;

  localparam int N_FLOORS_MAX = 16;
  localparam int FLOOR_W      = 4;
  localparam int TICK_W       = 32;

  typedef enum logic [1:0] {
    STOP = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MOVE = 2'b01,
    DOOR = 2'b10
  } state_e;

  // True when any call is registered strictly above the given floor.
  function automatic logic any_above(input logic [N_FLOORS_MAX-1:0] bitmap,
                                     input logic [FLOOR_W-1:0] floor);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_FLOORS_MAX; i++) begin
      if ((i > int'(floor)) && bitmap[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  // True when any call is registered strictly below the given floor.
  function automatic logic any_below(input logic [N_FLOORS_MAX-1:0] bitmap,
                                     input logic [FLOOR_W-1:0] floor);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_FLOORS_MAX; i++) begin
      if ((i < int'(floor)) && bitmap[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/lift_tick_timer.sv
// lift_tick_timer: up-counter with synchronous clear, enable and a terminal-count flag.
// Wraps to zero on the terminal count so back-to-back phases start cleanly.
module lift_tick_timer
  import smartlift_pkg::*;
#(
  parameter int CNT_W = TICK_W
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] count_reg;

  assign tc = (count_reg == term);

  // Count towards the terminal value; load forces the count back to zero.
  always_ff @(posedge clk) begin
    if (srst || load) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tc ? '0 : count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lift_scheduler.sv
// lift_scheduler: SCAN-order call scheduler and motion/door sequencer for the smartlift.
// Optional feature macro LIFT_DOOR_HOLD_EN adds the door_hold input, which freezes the
// door dwell at its start while asserted.
module lift_scheduler
  import smartlift_pkg::*;
#(
  parameter int N_FLOORS   = 9,
  parameter int MOVE_TICKS = 50000000,
  parameter int DOOR_TICKS = 100000000
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                req_strobe,
  input  logic [N_FLOORS-1:0] req_onehot,
`ifdef LIFT_DOOR_HOLD_EN
  input  logic                door_hold,
`endif
  output logic [3:0]          cur_floor,
  output logic [1:0]          dir,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy
);

  state_e                  state_reg, state_next;
  dir_e                    dir_reg, dir_next;
  logic [FLOOR_W-1:0]      floor_reg, floor_next;
  logic [N_FLOORS-1:0]     pending_reg, pending_next;

  logic [N_FLOORS-1:0]     cap_mask;
  logic [N_FLOORS_MAX-1:0] pend_ext;
  logic [N_FLOORS_MAX-1:0] req_ext;
  logic [N_FLOORS_MAX-1:0] step_onehot;
  logic [FLOOR_W-1:0]      floor_step;
  logic                    excl_cur;
  logic                    same_hit;
  logic                    stop_here;
  logic                    above;
  logic                    below;
  logic                    hold_active;
  logic                    tc;
  logic                    timer_load;
  logic                    timer_en;
  logic [TICK_W-1:0]       term;

`ifdef LIFT_DOOR_HOLD_EN
  assign hold_active = door_hold;
`else
  assign hold_active = 1'b0;
`endif

  // While parked or dwelling, a call for the current floor reopens/extends the door
  // instead of becoming a pending bit.
  assign excl_cur = (state_reg == IDLE) || (state_reg == DOOR);
  assign req_ext  = N_FLOORS_MAX'(req_onehot);
  assign same_hit = req_strobe && excl_cur && req_ext[floor_reg];

  for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_cap
    assign cap_mask[gi] = req_strobe && req_onehot[gi] &&
                          !(excl_cur && (floor_reg == FLOOR_W'(gi)));
  end

  assign pend_ext    = N_FLOORS_MAX'(pending_reg);
  assign above       = any_above(pend_ext, floor_reg);
  assign below       = any_below(pend_ext, floor_reg);
  assign floor_step  = (dir_reg == DOWN) ? floor_reg - FLOOR_W'(1) : floor_reg + FLOOR_W'(1);
  assign step_onehot = N_FLOORS_MAX'(1) << floor_step;
  assign stop_here   = pend_ext[floor_step];

  // One timer paces both phases; the terminal value follows the current state.
  assign term     = (state_reg == MOVE) ? TICK_W'(MOVE_TICKS - 1) : TICK_W'(DOOR_TICKS - 1);
  assign timer_en = (state_reg != IDLE);

  lift_tick_timer #(.CNT_W(TICK_W)) u_timer (
    .clk  (CLOCK_50),
    .srst (RESET),
    .load (timer_load),
    .en   (timer_en),
    .term (term),
    .tc   (tc)
  );

  // Next-state, direction, floor and call-bitmap decisions.
  always_comb begin
    state_next   = state_reg;
    dir_next     = dir_reg;
    floor_next   = floor_reg;
    pending_next = pending_reg | cap_mask;
    timer_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        dir_next   = STOP;
        timer_load = 1'b1;
        if (same_hit) begin
          state_next = DOOR;
        end else if (pending_reg != '0) begin
          state_next = MOVE;
          dir_next   = above ? UP : DOWN;
        end
      end
      MOVE: begin
        if (tc) begin
          floor_next = floor_step;
          // Clearing after the capture OR means a call for the arrival floor on the
          // same edge is treated as served.
          if (stop_here) begin
            state_next   = DOOR;
            pending_next = pending_next & ~step_onehot[N_FLOORS-1:0];
          end
        end
      end
      DOOR: begin
        if (same_hit || hold_active) begin
          timer_load = 1'b1;
        end else if (tc) begin
          // Keep going the same way while calls remain ahead; only reverse here,
          // which keeps the car inside the served range.
          if (dir_reg == DOWN) begin
            if (below) begin
              state_next = MOVE;
              dir_next   = DOWN;
            end else if (above) begin
              state_next = MOVE;
              dir_next   = UP;
            end else begin
              state_next = IDLE;
              dir_next   = STOP;
            end
          end else begin
            if (above) begin
              state_next = MOVE;
              dir_next   = UP;
            end else if (below) begin
              state_next = MOVE;
              dir_next   = DOWN;
            end else begin
              state_next = IDLE;
              dir_next   = STOP;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
        dir_next   = STOP;
      end
    endcase
  end

  // State register; reset discards position, direction and any outstanding calls.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_reg   <= IDLE;
      dir_reg     <= STOP;
      floor_reg   <= '0;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      dir_reg     <= dir_next;
      floor_reg   <= floor_next;
      pending_reg <= pending_next;
    end
  end

  assign cur_floor = floor_reg;
  assign dir       = dir_reg;
  assign door_open = (state_reg == DOOR);
  assign busy      = (state_reg != IDLE);
  assign pending   = pending_reg;

endmodule

// File: tb/tb_lift_scheduler.sv
// tb_lift_scheduler: directed scenario tasks plus a randomized run checked against a
// cycle-level behavioural model of the lift. Define LIFT_DOOR_HOLD_EN to cover door_hold.
`timescale 1ns/1ps
module tb_lift_scheduler;

  localparam int NF = 9;
  localparam int MT = 4;
  localparam int DT = 3;
`ifdef LIFT_DOOR_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_strobe;
  logic [NF-1:0] req_onehot;
`ifdef LIFT_DOOR_HOLD_EN
  logic          door_hold;
`endif
  logic [3:0]    cur_floor;
  logic [1:0]    dir;
  logic          door_open;
  logic [NF-1:0] pending;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: floor as an integer, direction as +1/-1/0, phase as
  // 0 idle / 1 moving / 2 door, and the cycles left in the current phase.
  int          m_floor;
  int          m_dir;
  int          m_phase;
  int          m_left;
  bit [NF-1:0] m_pend;

  always #5 clk = ~clk;

  lift_scheduler #(.N_FLOORS(NF), .MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .req_strobe (req_strobe),
    .req_onehot (req_onehot),
`ifdef LIFT_DOOR_HOLD_EN
    .door_hold  (door_hold),
`endif
    .cur_floor  (cur_floor),
    .dir        (dir),
    .door_open  (door_open),
    .pending    (pending),
    .busy       (busy)
  );

  function automatic bit m_any(input bit [NF-1:0] p, input int from, input int d);
    for (int f = from + d; f >= 0 && f < NF; f += d) begin
      if (p[f]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_dir_code(input int d);
    return (d == 1) ? 2'b01 : ((d == -1) ? 2'b10 : 2'b00);
  endfunction

  task automatic model_step(input bit r, input bit s, input bit [NF-1:0] req, input bit h);
    bit [NF-1:0] p;
    bit          same;
    int          first;
    if (r) begin
      m_floor = 0; m_dir = 0; m_phase = 0; m_left = 0; m_pend = '0;
      return;
    end
    p    = m_pend;
    same = 1'b0;
    for (int f = 0; f < NF; f++) begin
      if (s && req[f]) begin
        if (m_phase != 1 && f == m_floor) same = 1'b1;
        else m_pend[f] = 1'b1;
      end
    end
    case (m_phase)
      0: begin
        if (same) begin
          m_phase = 2; m_left = DT;
        end else if (p != '0) begin
          m_dir = m_any(p, m_floor, 1) ? 1 : -1;
          m_phase = 1; m_left = MT;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_dir;
          m_left = MT;
          if (p[m_floor]) begin
            m_pend[m_floor] = 1'b0;
            m_phase = 2; m_left = DT;
          end
        end
      end
      default: begin
        if (same || (h && HOLD_EN)) begin
          m_left = DT;
        end else begin
          m_left--;
          if (m_left == 0) begin
            first = (m_dir == -1) ? -1 : 1;
            if (m_any(p, m_floor, first)) begin
              m_dir = first; m_phase = 1; m_left = MT;
            end else if (m_any(p, m_floor, -first)) begin
              m_dir = -first; m_phase = 1; m_left = MT;
            end else begin
              m_dir = 0; m_phase = 0;
            end
          end
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs, step the model, and land 1 ns after the edge.
  task automatic tick(input bit r, input bit s, input bit [NF-1:0] req, input bit h);
    rst = r; req_strobe = s; req_onehot = req;
`ifdef LIFT_DOOR_HOLD_EN
    door_hold = h;
`endif
    if (s && !r) $display("[TB] t=%0t call req=%b at floor %0d", $time, req, cur_floor);
    model_step(r, s, req, h);
    @(posedge clk);
    #1;
    rst = 1'b0; req_strobe = 1'b0; req_onehot = '0;
`ifdef LIFT_DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
  endtask

  task automatic test_reset();
    tick(1, 0, '0, 0);
    tick(1, 0, '0, 0);
    n_tests++;
    if (cur_floor !== 4'd0 || dir !== 2'b00 || door_open !== 1'b0 || busy !== 1'b0 || pending !== '0) begin
      n_fail++;
      $display("FAIL reset: floor=%0d dir=%b door=%b busy=%b pending=%b, required all zero",
               cur_floor, dir, door_open, busy, pending);
    end
    tick(0, 0, '0, 0);
    n_tests++;
    if (busy !== 1'b0 || dir !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b dir=%b, required 0/00", busy, dir);
    end
  endtask

  task automatic test_single_call();
    int open_cycles;
    tick(1, 0, '0, 0);
    tick(0, 1, 9'b000000100, 0);
    n_tests++;
    if (pending !== 9'b000000100 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_capture: pending=%b busy=%b, required 000000100/0", pending, busy);
    end
    tick(0, 0, '0, 0);
    n_tests++;
    if (busy !== 1'b1 || dir !== 2'b01 || cur_floor !== 4'd0) begin
      n_fail++;
      $display("FAIL single_start: busy=%b dir=%b floor=%0d, required 1/01/0", busy, dir, cur_floor);
    end
    repeat (3) tick(0, 0, '0, 0);
    n_tests++;
    if (cur_floor !== 4'd0) begin
      n_fail++;
      $display("FAIL single_early: floor=%0d, required 0", cur_floor);
    end
    tick(0, 0, '0, 0);
    n_tests++;
    if (cur_floor !== 4'd1 || door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL single_floor1: floor=%0d door=%b, required 1/0", cur_floor, door_open);
    end
    repeat (4) tick(0, 0, '0, 0);
    n_tests++;
    if (cur_floor !== 4'd2 || door_open !== 1'b1 || pending !== '0) begin
      n_fail++;
      $display("FAIL single_arrive: floor=%0d door=%b pending=%b, required 2/1/0", cur_floor, door_open, pending);
    end
    open_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (door_open) open_cycles++;
      else break;
      tick(0, 0, '0, 0);
    end
    n_tests++;
    if (open_cycles != DT || busy !== 1'b0 || dir !== 2'b00 || pending !== '0) begin
      n_fail++;
      $display("FAIL single_dwell: open=%0d busy=%b dir=%b pending=%b, required %0d/0/00/0",
               open_cycles, busy, dir, pending, DT);
    end
  endtask

  task automatic test_scan();
    int          guard;
    int          nstops;
    bit          prev;
    int          got_floor[3];
    logic [1:0]  got_dir[3];
    logic [8:0]  got_pend[3];
    int          exp_floor[3];
    logic [1:0]  exp_dir[3];
    logic [8:0]  exp_pend[3];
    exp_floor[0] = 6; exp_dir[0] = 2'b01; exp_pend[0] = 9'b100000100;
    exp_floor[1] = 8; exp_dir[1] = 2'b01; exp_pend[1] = 9'b000000100;
    exp_floor[2] = 2; exp_dir[2] = 2'b10; exp_pend[2] = 9'b000000000;
    tick(1, 0, '0, 0);
    tick(0, 1, 9'b101000000, 0);
    guard = 0;
    while (cur_floor !== 4'd4 && guard < 60) begin
      tick(0, 0, '0, 0);
      guard++;
    end
    n_tests++;
    if (cur_floor !== 4'd4 || dir !== 2'b01) begin
      n_fail++;
      $display("FAIL scan_reach4: floor=%0d dir=%b, required 4/01", cur_floor, dir);
    end
    tick(0, 1, 9'b000000100, 0);
    n_tests++;
    if (pending !== 9'b101000100) begin
      n_fail++;
      $display("FAIL scan_pending: pending=%b, required 101000100", pending);
    end
    nstops = 0;
    prev   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(0, 0, '0, 0);
      if (door_open && !prev) begin
        if (nstops < 3) begin
          got_floor[nstops] = int'(cur_floor);
          got_dir[nstops]   = dir;
          got_pend[nstops]  = pending;
        end
        nstops++;
      end
      prev = door_open;
      if (!busy) break;
    end
    n_tests++;
    if (nstops != 3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_stops: stops=%0d busy=%b, required 3/0", nstops, busy);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (got_floor[k] != exp_floor[k] || got_dir[k] !== exp_dir[k] || got_pend[k] !== exp_pend[k]) begin
          n_fail++;
          $display("FAIL scan_stop%0d: floor=%0d dir=%b pending=%b, required %0d/%b/%b",
                   k, got_floor[k], got_dir[k], got_pend[k], exp_floor[k], exp_dir[k], exp_pend[k]);
        end
      end
    end
  endtask

  task automatic test_same_floor();
    bit exp_door[3];
    exp_door[0] = 1'b1; exp_door[1] = 1'b1; exp_door[2] = 1'b0;
    tick(1, 0, '0, 0);
    tick(0, 1, 9'b000001000, 0);
    for (int i = 0; i < 100; i++) begin
      tick(0, 0, '0, 0);
      if (!busy) break;
    end
    n_tests++;
    if (cur_floor !== 4'd3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL same_park: floor=%0d busy=%b, required 3/0", cur_floor, busy);
    end
    tick(0, 1, 9'b000001000, 0);
    n_tests++;
    if (door_open !== 1'b1 || pending !== '0 || dir !== 2'b00) begin
      n_fail++;
      $display("FAIL same_open: door=%b pending=%b dir=%b, required 1/0/00", door_open, pending, dir);
    end
    tick(0, 0, '0, 0);
    tick(0, 1, 9'b000001000, 0);
    n_tests++;
    if (door_open !== 1'b1 || pending !== '0) begin
      n_fail++;
      $display("FAIL same_restart: door=%b pending=%b, required 1/0", door_open, pending);
    end
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, '0, 0);
      n_tests++;
      if (door_open !== exp_door[k]) begin
        n_fail++;
        $display("FAIL same_dwell%0d: door=%b, required %b", k, door_open, exp_door[k]);
      end
    end
  endtask

  task automatic test_arrival_race();
    tick(1, 0, '0, 0);
    tick(0, 1, 9'b000100000, 0);
    tick(0, 0, '0, 0);
    repeat (19) tick(0, 0, '0, 0);
    n_tests++;
    if (cur_floor !== 4'd4 || busy !== 1'b1 || door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL race_approach: floor=%0d busy=%b door=%b, required 4/1/0", cur_floor, busy, door_open);
    end
    tick(0, 1, 9'b000100000, 0);
    n_tests++;
    if (cur_floor !== 4'd5 || door_open !== 1'b1 || pending !== '0) begin
      n_fail++;
      $display("FAIL race_arrive: floor=%0d door=%b pending=%b, required 5/1/0", cur_floor, door_open, pending);
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, '0, 0);
      if (!busy) break;
    end
    n_tests++;
    if (busy !== 1'b0 || pending !== '0 || cur_floor !== 4'd5) begin
      n_fail++;
      $display("FAIL race_after: busy=%b pending=%b floor=%0d, required 0/0/5", busy, pending, cur_floor);
    end
  endtask

  task automatic test_reset_mid_move();
    tick(1, 0, '0, 0);
    tick(0, 1, 9'b001000000, 0);
    for (int i = 0; i < 40; i++) begin
      if (cur_floor === 4'd3) break;
      tick(0, 0, '0, 0);
    end
    n_tests++;
    if (cur_floor !== 4'd3 || dir !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmove_pre: floor=%0d dir=%b, required 3/01", cur_floor, dir);
    end
    tick(1, 0, '0, 0);
    n_tests++;
    if (cur_floor !== 4'd0 || dir !== 2'b00 || door_open !== 1'b0 || busy !== 1'b0 || pending !== '0) begin
      n_fail++;
      $display("FAIL rstmove: floor=%0d dir=%b door=%b busy=%b pending=%b, required all zero",
               cur_floor, dir, door_open, busy, pending);
    end
    tick(0, 0, '0, 0);
    tick(0, 0, '0, 0);
    n_tests++;
    if (busy !== 1'b0 || pending !== '0) begin
      n_fail++;
      $display("FAIL rstmove_after: busy=%b pending=%b, required 0/0", busy, pending);
    end
  endtask

`ifdef LIFT_DOOR_HOLD_EN
  task automatic test_hold();
    bit exp_door[3];
    exp_door[0] = 1'b1; exp_door[1] = 1'b1; exp_door[2] = 1'b0;
    tick(1, 0, '0, 0);
    tick(0, 1, 9'b000000001, 0);
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, '0, 1);
      n_tests++;
      if (door_open !== 1'b1) begin
        n_fail++;
        $display("FAIL hold%0d: door=%b, required 1", k, door_open);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, '0, 0);
      n_tests++;
      if (door_open !== exp_door[k]) begin
        n_fail++;
        $display("FAIL hold_release%0d: door=%b, required %b", k, door_open, exp_door[k]);
      end
    end
  endtask
`endif

  task automatic test_random();
    bit          r;
    bit          s;
    bit          h;
    bit [NF-1:0] req;
    tick(1, 0, '0, 0);
    for (int cyc = 0; cyc < 2500; cyc++) begin
      r   = ($urandom_range(0, 399) == 0);
      s   = ($urandom_range(0, 7) == 0);
      req = (($urandom_range(0, 1) == 0) ? NF'(1) << $urandom_range(0, NF - 1)
                                         : NF'($urandom & $urandom));
      h   = ($urandom_range(0, 4) == 0);
      tick(r, s, req, h);
      n_tests++;
      if (cur_floor !== 4'(m_floor) || dir !== m_dir_code(m_dir) ||
          door_open !== (m_phase == 2) || busy !== (m_phase != 0) ||
          pending !== m_pend || cur_floor >= 4'(NF)) begin
        n_fail++;
        $display("FAIL random cyc %0d: floor=%0d/%0d dir=%b/%b door=%b/%b busy=%b/%b pending=%b/%b (dut/model)",
                 cyc, cur_floor, m_floor, dir, m_dir_code(m_dir), door_open, (m_phase == 2),
                 busy, (m_phase != 0), pending, m_pend);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_strobe = 1'b0; req_onehot = '0;
`ifdef LIFT_DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    m_floor = 0; m_dir = 0; m_phase = 0; m_left = 0; m_pend = '0;
    test_reset();
    test_single_call();
    test_scan();
    test_same_floor();
    test_arrival_race();
    test_reset_mid_move();
`ifdef LIFT_DOOR_HOLD_EN
    test_hold();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
